// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the multicycle processor. Holds the program
// counter, drives it as the word address of a combinational instruction
// memory, captures the returned word into the instruction register and
// presents it downstream through a valid/ack handshake. PC redirects from
// branches and R15 writes are applied via BR_TAKEN/BR_TARGET.
//
// Optional feature macro: FETCH_RANGE_CHECK_EN
//   defined     : a fetch from PC > MAX_ADDR captures nothing, raises the
//                 sticky FETCH_FAULT flag and parks the unit in FAULT until RST.
//   not defined : FETCH_FAULT is tied low, any address is fetched.
//
// Parameters
//   ADDR_W    width of PC and memory address
//   RESET_PC  PC value after reset
//   MAX_ADDR  highest legal fetch address (range check only)
//
// Ports
//   CLK          in   rising-edge clock
//   RST          in   asynchronous, active-high reset
//   FETCH_REQ    in   control unit permits a new fetch
//   IM_A         out  instruction memory address (equals PC)
//   IM_RD        in   instruction word, combinational in IM_A
//   INSTR        out  instruction register
//   INSTR_VALID  out  INSTR holds an unconsumed instruction
//   INSTR_ACK    in   downstream consumes INSTR
//   INSTR_PC     out  address INSTR was fetched from
//   PC_PLUS8     out  INSTR_PC + 8 (architectural R15 read value)
//   BR_TAKEN     in   redirect request
//   BR_TARGET    in   redirect address (low two bits are dropped)
//   FETCH_FAULT  out  sticky out-of-range fetch flag
//
// Handshake: INSTR_VALID is high exactly while the FSM is in HOLD, and INSTR /
// INSTR_PC are stable for that whole time. The instruction is consumed on a
// rising edge where INSTR_VALID=1 and either INSTR_ACK=1 or BR_TAKEN=1 (a
// redirect discards the held instruction and takes priority over the ack).
// INSTR_VALID never depends combinationally on any input.
//
// The FSM state is kept in state_q (type state_t) for observation.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 88
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FETCH_REQ,
    output logic [ADDR_W-1:0] IM_A,
    input  logic [31:0]       IM_RD,
    output logic [31:0]       INSTR,
    output logic              INSTR_VALID,
    input  logic              INSTR_ACK,
    output logic [ADDR_W-1:0] INSTR_PC,
    output logic [ADDR_W-1:0] PC_PLUS8,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TARGET,
    output logic              FETCH_FAULT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
`ifdef FETCH_RANGE_CHECK_EN
        ,
        ST_FAULT = 2'd3
`endif
    } state_t;

    // The PC is always word aligned, so reset and redirect values drop bits [1:0].
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0]   br_target_aligned;

    assign br_target_aligned = {BR_TARGET[ADDR_W-1:2], 2'b00};

`ifdef FETCH_RANGE_CHECK_EN
    logic fault_q, fault_d;
    logic pc_out_of_range;

    assign pc_out_of_range = (pc_q > MAX_ADDR);
`else
    // Only the range check consumes MAX_ADDR; the redirect drops BR_TARGET[1:0].
    logic unused_bits;
    assign unused_bits = ^{MAX_ADDR, BR_TARGET[1:0]};
`endif

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC_ALIGNED;
            instr_q    <= '0;
            instr_pc_q <= '0;
`ifdef FETCH_RANGE_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
`ifdef FETCH_RANGE_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
`ifdef FETCH_RANGE_CHECK_EN
        fault_d    = fault_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (BR_TAKEN) begin
                    pc_d = br_target_aligned;
                end
                if (FETCH_REQ) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // Redirects are ignored here: the fetch already in flight
                // completes and the PC simply advances.
`ifdef FETCH_RANGE_CHECK_EN
                if (pc_out_of_range) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    instr_d    = IM_RD;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + ADDR_W'(4);
                    state_d    = ST_HOLD;
                end
`else
                instr_d    = IM_RD;
                instr_pc_d = pc_q;
                pc_d       = pc_q + ADDR_W'(4);
                state_d    = ST_HOLD;
`endif
            end

            ST_HOLD: begin
                if (BR_TAKEN) begin
                    // Redirect wins over ack; the held instruction is dropped.
                    pc_d    = br_target_aligned;
                    state_d = FETCH_REQ ? ST_FETCH : ST_IDLE;
                end else if (INSTR_ACK) begin
                    state_d = FETCH_REQ ? ST_FETCH : ST_IDLE;
                end
            end

`ifdef FETCH_RANGE_CHECK_EN
            ST_FAULT: begin
                // Terminal until reset: every input is ignored.
                state_d = ST_FAULT;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign IM_A        = pc_q;
    assign INSTR       = instr_q;
    assign INSTR_PC    = instr_pc_q;
    assign PC_PLUS8    = instr_pc_q + ADDR_W'(8);
    assign INSTR_VALID = (state_q == ST_HOLD);
`ifdef FETCH_RANGE_CHECK_EN
    assign FETCH_FAULT = fault_q;
`else
    assign FETCH_FAULT = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the multicycle processor. Holds the program counter, drives the word address into the combinational instruction memory, and captures the returned word into an instruction register. Presents the instruction to the downstream decode/control unit through a valid/ack handshake. Applies PC redirects from branches and R15 writes.

## Interface
- ADDR_W, 32, width of PC and memory address
- RESET_PC, 32'h0, PC value after reset
- MAX_ADDR, 32'd88, highest legal fetch address (used only with range check)

- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- FETCH_REQ  in  1  control unit permits a new fetch
- IM_A  out  ADDR_W  address to instruction memory; equals PC
- IM_RD  in  32  instruction word from memory, combinational in IM_A
- INSTR  out  32  instruction register
- INSTR_VALID  out  1  INSTR holds an unconsumed instruction
- INSTR_ACK  in  1  downstream consumes INSTR
- INSTR_PC  out  ADDR_W  address INSTR was fetched from
- PC_PLUS8  out  ADDR_W  INSTR_PC + 8 (architectural R15 read value)
- BR_TAKEN  in  1  redirect request
- BR_TARGET  in  ADDR_W  redirect address
- FETCH_FAULT  out  1  sticky out-of-range fetch flag

## Operation
- States: IDLE, FETCH, HOLD, FAULT.
- IDLE: INSTR_VALID=0. If FETCH_REQ=1, go to FETCH.
- FETCH: IM_A=PC. On the clock edge:
  - INSTR<=IM_RD, INSTR_PC<=PC, PC<=PC+4.
  - Go to HOLD.
- HOLD: INSTR_VALID=1; INSTR is stable.
  - BR_TAKEN=1 has priority over ACK. On the edge: PC<={BR_TARGET[ADDR_W-1:2],2'b00} and INSTR_VALID drops. The held instruction counts as consumed. Next state is FETCH if FETCH_REQ=1, else IDLE.
  - INSTR_ACK=1 with BR_TAKEN=0: next state is FETCH if FETCH_REQ=1, else IDLE. PC is unchanged.
  - Neither is asserted: stay in HOLD and keep all registers.
- BR_TAKEN in IDLE also loads PC with the aligned target. In FETCH it is ignored.
- Arithmetic:
  - PC+4 and INSTR_PC+8 are modulo 2^ADDR_W; 32'hFFFFFFFC+4 wraps to 0.
  - PC[1:0] is always 00.
- FAULT state exists only with the range check (see Configuration).

## Timing
- Reset values, applied asynchronously while RST=1:
  - PC=RESET_PC, INSTR=0, INSTR_PC=0, INSTR_VALID=0, FETCH_FAULT=0.
  - State=IDLE. PC_PLUS8 reads 8.
- RST asserted mid-operation aborts any held instruction immediately. The first fetch after release needs FETCH_REQ=1.
- Latency: FETCH_REQ high in IDLE at edge n → FETCH in cycle n+1 → INSTR_VALID=1 after edge n+1.
- Peak throughput is one instruction per 2 cycles: FETCH, then HOLD with ACK and FETCH_REQ high.
- IM_A changes only on clock edges. IM_RD must settle within the FETCH cycle.
- INSTR, INSTR_PC and PC_PLUS8 change only on the FETCH→HOLD edge or on reset.

## Configuration
- FETCH_RANGE_CHECK_EN defined:
  - In FETCH, if PC>MAX_ADDR, nothing is captured, FETCH_FAULT<=1 and the state goes to FAULT.
  - FAULT holds INSTR_VALID=0, ignores all inputs, and is left only by RST.
- FETCH_RANGE_CHECK_EN not defined:
  - FETCH_FAULT is tied to 0 and there is no FAULT state.
  - Out-of-range addresses fetch whatever IM_RD returns.

## Test plan
- Reset, memory word 0 = 32'hE04F000F, FETCH_REQ=1, ACK held high → INSTR=E04F000F, INSTR_PC=0, PC_PLUS8=8, IM_A=4. The next INSTR_VALID comes exactly 2 cycles later.
- Hold ACK low for 5 cycles in HOLD → INSTR, INSTR_PC and IM_A stay constant. Raise ACK with FETCH_REQ=0 → IDLE, INSTR_VALID=0, PC unchanged.
- Holding INSTR_PC=0x48, assert BR_TAKEN with BR_TARGET=0x50 and ACK=1 → next fetch at IM_A=0x50, INSTR_PC=0x50, PC_PLUS8=0x58.
- BR_TARGET=0x53 → PC=0x50. BR_TAKEN during FETCH → ignored; PC becomes old PC+4.
- Assert RST asynchronously between edges while in HOLD → INSTR_VALID=0 and PC=RESET_PC immediately, before the next edge.
- FETCH_RANGE_CHECK_EN defined, MAX_ADDR=88, run sequentially to PC=92 → FETCH_FAULT=1, INSTR keeps the word from 88, no further IM_A change until RST. Without the macro → word at 92 is fetched and FETCH_FAULT=0.
